// File: rtl/seq_word_serializer_pkg.sv
// seq_word_serializer_pkg: state encoding and default word width shared by the serializer slice
package seq_word_serializer_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} ser_state_e;
endpackage

// File: rtl/seq_word_serializer_if.sv
// seq_word_serializer_if: word input handshake (in_data/in_valid from producer, in_ready back)
interface seq_word_serializer_if import seq_word_serializer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, in_valid, input in_ready);
  modport slave(input in_data, in_valid, output in_ready);
endinterface

// File: rtl/seq_word_serializer.sv
// seq_word_serializer: parallel-in/serial-out stage feeding the "1001" detector
//   clk        rising-edge clock
//   reset      asynchronous reset, active-low
//   bus        slave side of the word handshake (in_data, in_valid, in_ready)
//   dout       registered serial bit (IDLE_LEVEL when no word is shifting)
//   dout_valid registered, high on every word bit
//   last       registered, high on the final bit of a word
//   busy       word in flight
module seq_word_serializer import seq_word_serializer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_word_serializer_if.slave  bus,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  last,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH);
  ser_state_e state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic dout_n, dout_valid_n, last_n, accept;
  // cnt counts bits still to come after the one on dout, so cnt==0 means the
  // last bit is showing and a new word can be taken without a bubble
  assign bus.in_ready = (state == ST_IDLE) || (cnt == '0);
  assign accept = bus.in_valid && bus.in_ready;
  assign busy = state == ST_SHIFT;
  // the first bit goes straight to the dout register on accept; sr keeps the rest
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    dout_n = dout;
    dout_valid_n = dout_valid;
    last_n = last;
    if (accept) begin
      state_n = ST_SHIFT;
      dout_n = MSB_FIRST ? bus.in_data[WIDTH-1] : bus.in_data[0];
      sr_n = MSB_FIRST ? bus.in_data << 1 : bus.in_data >> 1;
      cnt_n = CW'(WIDTH - 1);
      dout_valid_n = 1'b1;
      last_n = 1'b0;
    end else if (state == ST_SHIFT && cnt != '0) begin
      dout_n = MSB_FIRST ? sr[WIDTH-1] : sr[0];
      sr_n = MSB_FIRST ? sr << 1 : sr >> 1;
      cnt_n = cnt - 1'b1;
      last_n = cnt == CW'(1);
    end else begin
      state_n = ST_IDLE;
      dout_n = IDLE_LEVEL;
      dout_valid_n = 1'b0;
      last_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      sr <= '0;
      cnt <= '0;
      dout <= IDLE_LEVEL;
      dout_valid <= 1'b0;
      last <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      dout <= dout_n;
      dout_valid <= dout_valid_n;
      last <= last_n;
    end
  end
endmodule

// File: tb/tb_seq_word_serializer.sv
// tb_seq_word_serializer: directed checks of an MSB-first/idle-0 and an LSB-first/idle-1 serializer
module tb_seq_word_serializer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  seq_word_serializer_if #(.WIDTH(8)) bus ();
  seq_word_serializer_if #(.WIDTH(8)) bus_l ();
  logic dout, dv, last, busy, dout_l, dv_l, last_l, busy_l;
  seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .dout(dout), .dout_valid(dv), .last(last), .busy(busy)
  );
  seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
    .clk(clk), .reset(reset), .bus(bus_l),
    .dout(dout_l), .dout_valid(dv_l), .last(last_l), .busy(busy_l)
  );
  int total = 0;
  int passed = 0;
  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
    int hits;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic drive(logic v, logic [7:0] d);
    bus.in_valid = v;
    bus.in_data = d;
    bus_l.in_valid = v;
    bus_l.in_data = d;
  endtask
  task automatic chk_idle(string nm);
    chk({nm, "_dv"}, dv, 0);
    chk({nm, "_dout"}, dout, 0);
    chk({nm, "_dout_l"}, dout_l, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_last"}, last, 0);
    chk({nm, "_dv_l"}, dv_l, 0);
    chk({nm, "_ready"}, bus.in_ready, 1);
  endtask
  // em/el hold the expected streams, first bit in [7]; pulse toggles in_valid and
  // in_data while the word is in flight to show they are ignored
  task automatic run_word(logic [7:0] w, logic [7:0] em, logic [7:0] el, int hits, bit pulse);
    int h = 0;
    logic [3:0] hist = '0;
    @(negedge clk);
    drive(1'b1, w);
    chk("accept_ready", bus.in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("w%02h_bit%0d", w, k), dout, em[7-k]);
      chk($sformatf("w%02h_lsb_bit%0d", w, k), dout_l, el[7-k]);
      chk($sformatf("w%02h_dv%0d", w, k), dv & dv_l, 1);
      chk($sformatf("w%02h_last%0d", w, k), {last, last_l}, (k == 7) ? 2'b11 : 2'b00);
      chk($sformatf("w%02h_busy%0d", w, k), busy & busy_l, 1);
      chk($sformatf("w%02h_ready%0d", w, k), bus.in_ready, k == 7);
      hist = {hist[2:0], dout};
      if (hist == 4'b1001) h++;
      drive(pulse && k >= 1 && k <= 5, pulse ? ~w : w);
    end
    chk($sformatf("w%02h_det_hits", w), h, hits);
    @(negedge clk);
    chk_idle("after_word");
  endtask
  initial begin
    logic [15:0] b2b;
    vecs[0] = '{8'b1001_0000, 8'b1001_0000, 8'b0000_1001, 1};
    vecs[1] = '{8'b0000_1001, 8'b0000_1001, 8'b1001_0000, 1};
    vecs[2] = '{8'hA5, 8'b1010_0101, 8'b1010_0101, 1};
    vecs[3] = '{8'h3C, 8'b0011_1100, 8'b0011_1100, 0};
    vecs[4] = '{8'h81, 8'b1000_0001, 8'b1000_0001, 0};
    vecs[5] = '{8'h01, 8'b0000_0001, 8'b1000_0000, 0};
    vecs[6] = '{8'hE2, 8'b1110_0010, 8'b0100_0111, 0};
    drive(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk_idle("in_reset");
    reset = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");
    foreach (vecs[i]) run_word(vecs[i].word, vecs[i].exp_m, vecs[i].exp_l, vecs[i].hits, 1'b0);
    b2b = 16'b1001_1001_1001_0000;
    @(negedge clk);
    drive(1'b1, 8'h99);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_bit%0d", k), dout, b2b[15-k]);
      chk($sformatf("b2b_dv%0d", k), dv, 1);
      chk($sformatf("b2b_last%0d", k), last, (k % 8) == 7);
      if (k < 15) chk($sformatf("b2b_ready%0d", k), bus.in_ready, k == 7);
      if (k == 7) drive(1'b1, 8'h90);
      if (k == 15) drive(1'b0, 8'h90);
    end
    @(negedge clk);
    chk_idle("b2b_end");
    @(negedge clk);
    drive(1'b1, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 8'hFF);
      chk($sformatf("ff_bit%0d", k), dout, 1);
    end
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_dout", dout, 0);
    chk("rst_mid_dv", dv, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_dout_l", dout_l, 1);
    #3 reset = 1'b1;
    run_word(8'h90, 8'b1001_0000, 8'b0000_1001, 1, 1'b0);
    run_word(8'hA5, 8'b1010_0101, 8'b1010_0101, 1, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
